// File: rtl/radar_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : radar_scan_ctrl
// Purpose  : Sequences a 4-position servo sweep. For each position it moves
//            the servo, waits for it to settle, triggers one ultrasonic
//            measurement, waits for the result (or a timeout) and presents
//            the result on a valid/ready interface.
// Ports    : clk          - system clock, all registers on rising edge
//            reset        - synchronous, active-low
//            enable       - 1: continuous scan, 0: park after current position
//            angle        - servo position select (0..3)
//            meas_start   - one-cycle measurement trigger
//            meas_done    - one-cycle completion pulse, qualifies distance_in
//            distance_in  - measured distance
//            res_valid    - result available, held until accepted
//            res_ready    - consumer accept
//            res_angle    - position the result was taken at
//            res_distance - distance, 16'hFFFF on timeout
//            res_timeout  - result came from a timeout
//            busy         - controller is not idle
// Options  : RADAR_MIN_TRACK_EN adds min_distance, min_angle and sweep_done,
//            reporting the nearest echo of each completed 0..3 sweep.
// Revision : 1.0 - initial release
// ============================================================================
module radar_scan_ctrl #(
    parameter int unsigned SETTLE_CYC  = 50000000,
    parameter int unsigned TIMEOUT_CYC = 3000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [1:0]  angle,
    output logic        meas_start,
    input  logic        meas_done,
    input  logic [15:0] distance_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [1:0]  res_angle,
    output logic [15:0] res_distance,
    output logic        res_timeout,
    output logic        busy
`ifdef RADAR_MIN_TRACK_EN
    ,
    output logic [15:0] min_distance,
    output logic [1:0]  min_angle,
    output logic        sweep_done
`endif
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_MOVE   = 3'd1;
    localparam logic [2:0] c_ST_SETTLE = 3'd2;
    localparam logic [2:0] c_ST_TRIG   = 3'd3;
    localparam logic [2:0] c_ST_WAIT   = 3'd4;
    localparam logic [2:0] c_ST_RESULT = 3'd5;

    localparam logic [31:0] c_SETTLE_CYC  = 32'(SETTLE_CYC);
    localparam logic [31:0] c_TIMEOUT_CYC = 32'(TIMEOUT_CYC);
    localparam logic [31:0] c_CNT_MAX     = 32'hFFFF_FFFF;
    localparam logic [15:0] c_NO_ECHO     = 16'hFFFF;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_settle_cnt;
    logic [31:0] r_timeout_cnt;
    logic [1:0]  r_angle;
    logic [1:0]  r_next_pos;
    logic [1:0]  r_res_angle;
    logic [15:0] r_res_distance;
    logic        r_res_timeout;
    logic        w_settle_done;
    logic        w_timeout;
    logic        w_accept;

    // Counters start at 0 on the first cycle of their state, so the last
    // cycle of an N-cycle stay is count N-1. A zero setting still spends one
    // cycle in the state.
    assign w_settle_done = (c_SETTLE_CYC == 32'd0) ||
                           (r_settle_cnt >= (c_SETTLE_CYC - 32'd1));
    assign w_timeout     = (c_TIMEOUT_CYC == 32'd0) ||
                           (r_timeout_cnt >= (c_TIMEOUT_CYC - 32'd1));
    assign w_accept      = (r_state == c_ST_RESULT) && res_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        meas_start  = 1'b0;
        res_valid   = 1'b0;
        busy        = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_IDLE: begin
                if (enable) w_state_nxt = c_ST_MOVE;
            end
            c_ST_MOVE: begin
                w_state_nxt = c_ST_SETTLE;
            end
            c_ST_SETTLE: begin
                if (w_settle_done) w_state_nxt = c_ST_TRIG;
            end
            c_ST_TRIG: begin
                meas_start  = 1'b1;
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (meas_done || w_timeout) w_state_nxt = c_ST_RESULT;
            end
            c_ST_RESULT: begin
                res_valid = 1'b1;
                // enable is only consulted here and in IDLE, so dropping it
                // mid-position never aborts the measurement in flight.
                if (res_ready) w_state_nxt = enable ? c_ST_MOVE : c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Position, counters and result capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_angle        <= 2'd0;
            r_next_pos     <= 2'd0;
            r_settle_cnt   <= 32'd0;
            r_timeout_cnt  <= 32'd0;
            r_res_angle    <= 2'd0;
            r_res_distance <= 16'd0;
            r_res_timeout  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_MOVE: begin
                    // r_next_pos keeps the first position after reset at 0;
                    // the 2-bit increment wraps 3 -> 0.
                    r_angle      <= r_next_pos;
                    r_next_pos   <= r_next_pos + 2'd1;
                    r_settle_cnt <= 32'd0;
                end
                c_ST_SETTLE: begin
                    if (r_settle_cnt != c_CNT_MAX) r_settle_cnt <= r_settle_cnt + 32'd1;
                end
                c_ST_TRIG: begin
                    r_timeout_cnt <= 32'd0;
                end
                c_ST_WAIT: begin
                    // meas_done is tested first so it wins a tie with expiry.
                    if (meas_done) begin
                        r_res_distance <= distance_in;
                        r_res_timeout  <= 1'b0;
                        r_res_angle    <= r_angle;
                    end else if (w_timeout) begin
                        r_res_distance <= c_NO_ECHO;
                        r_res_timeout  <= 1'b1;
                        r_res_angle    <= r_angle;
                    end else if (r_timeout_cnt != c_CNT_MAX) begin
                        r_timeout_cnt <= r_timeout_cnt + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign angle        = r_angle;
    assign res_angle    = r_res_angle;
    assign res_distance = r_res_distance;
    assign res_timeout  = r_res_timeout;

`ifdef RADAR_MIN_TRACK_EN
    logic [15:0] r_run_min;
    logic [1:0]  r_run_angle;
    logic [15:0] r_min_distance;
    logic [1:0]  r_min_angle;
    logic        r_sweep_done;
    logic        w_min_upd;
    logic [15:0] w_min_d;
    logic [1:0]  w_min_a;

    // Strictly-less keeps the earlier angle on ties; timeouts never count.
    assign w_min_upd = !r_res_timeout && (r_res_distance < r_run_min);
    assign w_min_d   = w_min_upd ? r_res_distance : r_run_min;
    assign w_min_a   = w_min_upd ? r_res_angle    : r_run_angle;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_run_min      <= c_NO_ECHO;
            r_run_angle    <= 2'd0;
            r_min_distance <= c_NO_ECHO;
            r_min_angle    <= 2'd0;
            r_sweep_done   <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            if (w_accept) begin
                if (r_res_angle == 2'd3) begin
                    // Sweep closes on the position-3 result, which is folded
                    // into the latched minimum before the tracker restarts.
                    r_min_distance <= w_min_d;
                    r_min_angle    <= w_min_a;
                    r_sweep_done   <= 1'b1;
                    r_run_min      <= c_NO_ECHO;
                    r_run_angle    <= 2'd0;
                end else begin
                    r_run_min   <= w_min_d;
                    r_run_angle <= w_min_a;
                end
            end
        end
    end

    assign min_distance = r_min_distance;
    assign min_angle    = r_min_angle;
    assign sweep_done   = r_sweep_done;
`endif

endmodule
`default_nettype wire

// File: doc/radar_scan_ctrl.md
RADAR_SCAN_CTRL -- requirements
Module: radar_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 50000000: servo settle wait per position, in clk cycles (500 ms at 100 MHz).
REQ-002 Parameter TIMEOUT_CYC, default 3000000: maximum wait for measurement completion, in clk cycles (30 ms).
REQ-003 Port clk, input, 1: single system clock; every register samples on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-low.
REQ-005 Port enable, input, 1: level; 1 runs a continuous scan, 0 parks the block after the current position.
REQ-006 Port angle, output, 2: servo position select, drives the servo position input.
REQ-007 Port meas_start, output, 1: one-cycle pulse that starts an ultrasonic measurement.
REQ-008 Port meas_done, input, 1: single-cycle pulse from the ultrasonic block; distance_in is valid in that cycle.
REQ-009 Port distance_in, input, 16: measured distance from the ultrasonic block.
REQ-010 Port res_valid, output, 1: result available; held until accepted.
REQ-011 Port res_ready, input, 1: consumer accept.
REQ-012 Port res_angle, output, 2: position at which the result was taken.
REQ-013 Port res_distance, output, 16: measured distance, or 16'hFFFF on timeout.
REQ-014 Port res_timeout, output, 1: 1 when the result came from a timeout.
REQ-015 Port busy, output, 1: 1 whenever the FSM is not in IDLE.

Function
REQ-016 FSM states are IDLE, MOVE, SETTLE, TRIG, WAIT and RESULT; the state register is exclusive to this block.
REQ-017 IDLE: when enable=1, go to MOVE; otherwise hold; angle keeps its last value.
REQ-018 MOVE, one cycle: angle <= next position; the settle counter clears; go to SETTLE.
REQ-019 Position order is 0,1,2,3,0,...; wrap from 3 to 0; the first position after reset is 0.
REQ-020 SETTLE: stay exactly SETTLE_CYC cycles, then go to TRIG; SETTLE_CYC=0 gives a one-cycle pass-through.
REQ-021 TRIG, one cycle: meas_start=1; the timeout counter clears; go to WAIT.
REQ-022 meas_start is 1 only in TRIG: exactly one pulse per position.
REQ-023 WAIT on meas_done=1: res_distance <= distance_in; res_timeout <= 0; res_angle <= angle; go to RESULT.
REQ-024 WAIT, timeout: after TIMEOUT_CYC cycles without meas_done, res_distance <= 16'hFFFF; res_timeout <= 1; res_angle <= angle; go to RESULT.
REQ-025 WAIT, simultaneous meas_done and timeout expiry in the same cycle: meas_done wins.
REQ-026 meas_done outside WAIT is ignored.
REQ-027 RESULT: res_valid=1; res_angle, res_distance and res_timeout stay stable until res_valid and res_ready are both 1.
REQ-028 On acceptance: res_valid drops the next cycle; go to MOVE if enable=1, else IDLE.
REQ-029 res_ready=1 already on RESULT entry: the result is accepted in the first RESULT cycle, so RESULT lasts one cycle.
REQ-030 enable deasserted in MOVE, SETTLE, TRIG or WAIT: the current position completes through RESULT handshake, then IDLE; no abort.
REQ-031 Counters are 32-bit and unsigned; the settle and timeout counters saturate rather than wrap.
REQ-032 Latency, enable rising in IDLE to meas_start: 1 (MOVE) + SETTLE_CYC + 1 cycles.

Reset
REQ-033 reset=0 at a clk edge forces, from any state: state=IDLE; angle=0; meas_start=0; res_valid=0; res_angle=0; res_distance=0; res_timeout=0; busy=0; counters=0.
REQ-034 Reset mid-measurement discards the pending result; a meas_done arriving afterwards is ignored.
REQ-035 With RADAR_MIN_TRACK_EN defined, reset also sets min_distance=16'hFFFF, min_angle=0, sweep_done=0 and the running minimum to 16'hFFFF.

Configuration
REQ-036 Macro RADAR_MIN_TRACK_EN, when defined, adds three outputs: min_distance (16), min_angle (2) and sweep_done (1).
REQ-037 Running minimum: on each accepted non-timeout result whose distance is strictly less than the running minimum, the minimum and its angle update; ties keep the earlier angle.
REQ-038 On acceptance of the position-3 result: min_distance and min_angle latch the sweep minimum (including that result); sweep_done pulses 1 cycle; the running minimum restarts at 16'hFFFF.
REQ-039 An all-timeout sweep latches min_distance=16'hFFFF and min_angle=0.
REQ-040 Without the macro, none of these ports, registers or logic exist; all other behaviour is identical.

Verification (SETTLE_CYC=4, TIMEOUT_CYC=20)
REQ-041 Normal cycle: reset, enable=1, res_ready=1, meas_done 3 cycles after meas_start with distance_in=16'd100 -> meas_start 6 cycles after enable; result angle=0, distance=100, timeout=0; next angle=1.
REQ-042 Timeout: no meas_done -> res_valid 21 cycles after meas_start; res_distance=16'hFFFF; res_timeout=1.
REQ-043 Backpressure: res_ready=0 for 10 cycles -> res_valid and the result fields stay stable; no new meas_start until acceptance.
REQ-044 Wrap and stop: run 5 positions -> angles 0,1,2,3,0; drop enable during SETTLE -> position completes, then IDLE with busy=0 and angle held.
REQ-045 Reset in WAIT, then meas_done -> all outputs at reset values; no res_valid.
REQ-046 RADAR_MIN_TRACK_EN, distances 50,30,30,80 -> sweep_done pulse; min_distance=30; min_angle=1.
